// File: rtl/algo_1r1w_t1_mem_resp.sv
// Cycle-accurate 1W/1R SRAM stand-in for one t1 bank: zero-fills itself after reset, then serves
// reads with SRAM_DELAY latency. Optional MEM_RDWR_BYPASS_EN makes same-row same-cycle read write-first.
module algo_1r1w_t1_mem_resp #(
  parameter int WIDTH      = 32,
  parameter int NUMADDR    = 256,
  parameter int BITADDR    = 8,
  parameter int SRAM_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic [BITADDR-1:0] wr_adr,
  input  logic [WIDTH-1:0]   bw,
  input  logic [WIDTH-1:0]   din,
  input  logic               read,
  input  logic [BITADDR-1:0] rd_adr,
  output logic               rd_vld,
  output logic [WIDTH-1:0]   rd_dout,
  output logic               rd_err,
  output logic               ready,
  output logic               cmd_err
);

  localparam int AW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
  localparam logic [BITADDR:0]   NROWS = (BITADDR+1)'(NUMADDR);
  localparam logic [BITADDR-1:0] LAST  = BITADDR'(NUMADDR-1);

  typedef enum logic {ST_INIT, ST_READY} st_e;

  st_e                state_q;
  logic [BITADDR-1:0] init_cnt_q;
  logic               ready_q, cmd_err_q;
  logic [WIDTH-1:0]   mem_q [NUMADDR];

  logic [SRAM_DELAY-1:0]            vld_pipe_q, err_pipe_q;
  logic [SRAM_DELAY-1:0][WIDTH-1:0] dat_pipe_q;

  logic             wr_in, rd_oob, wr_ok, rd_acc;
  logic [WIDTH-1:0] rd_word_d;

  assign wr_in  = {1'b0, wr_adr} < NROWS;
  assign rd_oob = {1'b0, rd_adr} >= NROWS;
  assign wr_ok  = ready_q && write && wr_in;
  assign rd_acc = ready_q && read;

  // Data is captured in the accept cycle; later writes cannot reach it in the pipe.
  always_comb begin
    rd_word_d = '0;
    if (!rd_oob) rd_word_d = mem_q[rd_adr[AW-1:0]];
`ifdef MEM_RDWR_BYPASS_EN
    if (wr_ok && (wr_adr == rd_adr)) rd_word_d = (rd_word_d & ~bw) | (din & bw);
`endif
  end

  // Array has no reset; INIT sweeps zeros through every row instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)
      mem_q[init_cnt_q[AW-1:0]] <= '0;
    else if (wr_ok)
      mem_q[wr_adr[AW-1:0]] <= (mem_q[wr_adr[AW-1:0]] & ~bw) | (din & bw);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
      if ((!ready_q && (write || read)) || (ready_q && write && !wr_in))
        cmd_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      for (int i = SRAM_DELAY-1; i > 0; i--) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        err_pipe_q[i] <= err_pipe_q[i-1];
        dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
      vld_pipe_q[0] <= rd_acc;
      err_pipe_q[0] <= rd_acc && rd_oob;
      dat_pipe_q[0] <= rd_acc ? rd_word_d : '0;
    end
  end

  assign rd_vld  = vld_pipe_q[SRAM_DELAY-1];
  assign rd_err  = err_pipe_q[SRAM_DELAY-1];
  assign rd_dout = dat_pipe_q[SRAM_DELAY-1];
  assign ready   = ready_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_algo_1r1w_t1_mem_resp.sv
// Scoreboard bench: two responders (256 and 200 rows) share stimulus; monitors check every read return.
module tb_algo_1r1w_t1_mem_resp;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst, write, read;
  logic [7:0]  wr_adr, rd_adr;
  logic [31:0] bw, din;
  logic        v0, er0, rdy0, ce0, v1, er1, rdy1, ce1;
  logic [31:0] d0, d1;

  typedef struct { logic [31:0] d; logic e; int c; } exp_t;
  exp_t q0[$], q1[$];
  exp_t m0, m1;
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] t4_exp;

  algo_1r1w_t1_mem_resp #(.WIDTH(32), .NUMADDR(256), .BITADDR(8), .SRAM_DELAY(SD)) u0 (
    .clk(clk), .rst(rst), .write(write), .wr_adr(wr_adr), .bw(bw), .din(din),
    .read(read), .rd_adr(rd_adr), .rd_vld(v0), .rd_dout(d0), .rd_err(er0),
    .ready(rdy0), .cmd_err(ce0));

  algo_1r1w_t1_mem_resp #(.WIDTH(32), .NUMADDR(200), .BITADDR(8), .SRAM_DELAY(SD)) u1 (
    .clk(clk), .rst(rst), .write(write), .wr_adr(wr_adr), .bw(bw), .din(din),
    .read(read), .rd_adr(rd_adr), .rd_vld(v1), .rd_dout(d1), .rd_err(er1),
    .ready(rdy1), .cmd_err(ce1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (v0) begin
      if (q0.size() == 0) chk("u0_unexpected_vld", 32'(v0), 32'd0);
      else begin
        m0 = q0.pop_front();
        chk("u0_data", d0, m0.d);
        chk("u0_err", 32'(er0), 32'(m0.e));
        chk("u0_latency", cyc, m0.c);
      end
    end else begin
      chk("u0_idle_out", {d0[31:1], d0[0] | er0}, 32'd0);
      if (q0.size() > 0 && q0[0].c < cyc) begin
        chk("u0_missing_vld", 32'(v0), 32'd1);
        void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) chk("u1_unexpected_vld", 32'(v1), 32'd0);
      else begin
        m1 = q1.pop_front();
        chk("u1_data", d1, m1.d);
        chk("u1_err", 32'(er1), 32'(m1.e));
        chk("u1_latency", cyc, m1.c);
      end
    end else begin
      chk("u1_idle_out", {d1[31:1], d1[0] | er1}, 32'd0);
      if (q1.size() > 0 && q1[0].c < cyc) begin
        chk("u1_missing_vld", 32'(v1), 32'd1);
        void'(q1.pop_front());
      end
    end
  end

  // One cycle of stimulus; a read pushes the hand-computed response for each instance.
  task automatic step(input logic w, input logic [7:0] wa, input logic [31:0] b, input logic [31:0] d,
                      input logic r, input logic [7:0] ra,
                      input logic [31:0] e0, input logic [31:0] e1, input logic ee1);
    write = w; wr_adr = wa; bw = b; din = d; read = r; rd_adr = ra;
    if (r) begin
      q0.push_back('{e0, 1'b0, cyc + SD});
      q1.push_back('{e1, ee1, cyc + SD});
    end
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] b, input logic [31:0] d);
    step(1'b1, a, b, d, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1, input logic ee1);
    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b1, a, e0, e1, ee1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(output int n0, output int n1);
    n0 = 0; n1 = -1;
    while (!rdy0 && n0 < 1000) begin
      @(posedge clk); #1; n0++;
      if (rdy1 && n1 < 0) n1 = n0;
    end
  endtask

  initial begin
    int n0, n1;
`ifdef MEM_RDWR_BYPASS_EN
    t4_exp = 32'hAAAA5555;
`else
    t4_exp = 32'h12345678;
`endif
    rst = 1'b0; write = 1'b0; read = 1'b0; wr_adr = '0; rd_adr = '0; bw = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_cmd_err0", 32'(ce0), 32'd0);
    chk("rst_vld0", 32'(v0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    rst = 1'b1;
    wait_ready(n0, n1);
    chk("init_len_256", n0, 32'd256);
    chk("init_len_200", n1, 32'd200);
    chk("cmd_err0_after_init", 32'(ce0), 32'd0);

    rd(8'd17, 32'd0, 32'd0, 1'b0);
    wr(8'd5, 32'hFFFFFFFF, 32'hDEADBEEF);
    wr(8'd5, 32'h0000FFFF, 32'h00000000);
    rd(8'd5, 32'hDEAD0000, 32'hDEAD0000, 1'b0);

    wr(8'd1, 32'hFFFFFFFF, 32'h11);
    wr(8'd2, 32'hFFFFFFFF, 32'h22);
    wr(8'd3, 32'hFFFFFFFF, 32'h33);
    rd(8'd1, 32'h11, 32'h11, 1'b0);
    rd(8'd2, 32'h22, 32'h22, 1'b0);
    rd(8'd3, 32'h33, 32'h33, 1'b0);

    wr(8'd9, 32'hFFFFFFFF, 32'h12345678);
    step(1'b1, 8'd9, 32'hFFFFFFFF, 32'hAAAA5555, 1'b1, 8'd9, t4_exp, t4_exp, 1'b0);
    rd(8'd9, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
    wr(8'd9, 32'h00000000, 32'hFFFFFFFF);
    rd(8'd9, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
    step(1'b1, 8'd2, 32'hFFFFFFFF, 32'h77, 1'b1, 8'd3, 32'h33, 32'h33, 1'b0);

    rd(8'd1, 32'h11, 32'h11, 1'b0);
    wr(8'd1, 32'hFFFFFFFF, 32'h99);
    rd(8'd1, 32'h99, 32'h99, 1'b0);

    rd(8'd250, 32'd0, 32'd0, 1'b1);
    wr(8'd199, 32'hFFFFFFFF, 32'h5A);
    rd(8'd199, 32'h5A, 32'h5A, 1'b0);
    wr(8'd210, 32'hFFFFFFFF, 32'h77);
    rd(8'd210, 32'h77, 32'd0, 1'b1);
    wr(8'd255, 32'hFFFFFFFF, 32'hC3);
    rd(8'd255, 32'hC3, 32'd0, 1'b1);
    chk("cmd_err1_oob_write", 32'(ce1), 32'd1);
    chk("cmd_err0_inrange", 32'(ce0), 32'd0);
    idle(SD + 3);
    chk("q_drained_a", q0.size() + q1.size(), 32'd0);

    // In-flight read is killed by reset one cycle after issue.
    write = 1'b0; read = 1'b1; rd_adr = 8'd5;
    @(posedge clk); #1;
    read = 1'b0; rst = 1'b0;
    idle(2);
    chk("rst2_cmd_err0", 32'(ce0), 32'd0);
    chk("rst2_cmd_err1", 32'(ce1), 32'd0);
    chk("rst2_ready0", 32'(rdy0), 32'd0);
    rst = 1'b1;
    idle(10);
    read = 1'b1; rd_adr = 8'd5;
    @(posedge clk); #1;
    read = 1'b0;
    chk("cmd_err0_not_ready", 32'(ce0), 32'd1);
    chk("cmd_err1_not_ready", 32'(ce1), 32'd1);
    wait_ready(n0, n1);
    chk("reinit_ready0", 32'(rdy0), 32'd1);
    rd(8'd5, 32'd0, 32'd0, 1'b0);
    rd(8'd9, 32'd0, 32'd0, 1'b0);
    idle(SD + 3);
    chk("q_drained_b", q0.size() + q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
